ym2203_wr_seq: RTL and testbench
================================

YM2203_WR_SEQ -- requirements
Module: ym2203_wr_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_WAIT, default 17, cen ticks idle after an address write.
REQ-003 SHALL have parameter DATA_WAIT_FM, default 83, cen ticks idle after a data write to reg 0x10-0xFF.
REQ-004 SHALL have parameter DATA_WAIT_SSG, default 0, cen ticks idle after a data write to reg 0x00-0x0F.
REQ-005 SHALL have parameter CHIP_RST_CYC, default 8, cen ticks ym_rst is held after reset release.
REQ-006 SHALL have ports: clk  in  1  single clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: cen in 1, chip clock enable; cmd_valid in 1; cmd_ready out 1; cmd_reg in 8; cmd_data in 8.
REQ-008 SHALL have ports: ym_rst out 1, active-high chip reset; ym_cs_n out 1; ym_wr_n out 1; ym_addr out 1; ym_din out 8.
REQ-009 SHALL have ports: busy out 1, FIFO non-empty or sequencer not IDLE; fifo_ovf out 1, sticky push-while-full flag.

Function
REQ-010 SHALL accept a command when cmd_valid && cmd_ready at a clk edge, independent of cen.
REQ-011 SHALL drive cmd_ready = !full from registered state, so a pop in the same cycle does not raise ready.
REQ-012 SHALL set fifo_ovf when cmd_valid && !cmd_ready, cleared only by reset.
REQ-013 SHALL use states RST_HOLD, IDLE, ADDR_WR, ADDR_WAIT, DATA_WR, DATA_WAIT, and advance only on clk edges with cen=1.
REQ-014 RST_HOLD: ym_rst=1; count CHIP_RST_CYC cen ticks, then go to IDLE with ym_rst=0.
REQ-015 IDLE: on a cen tick with the FIFO non-empty, pop the head and go to ADDR_WR; if empty, stay in IDLE.
REQ-016 ADDR_WR: ym_cs_n=ym_wr_n=0, ym_addr=0, ym_din=reg for exactly one cen period; then go to ADDR_WAIT with counter=ADDR_WAIT.
REQ-017 DATA_WR: ym_cs_n=ym_wr_n=0, ym_addr=1, ym_din=data for exactly one cen period; then go to DATA_WAIT with counter = DATA_WAIT_SSG if reg<0x10, else DATA_WAIT_FM.
REQ-018 A WAIT state SHALL decrement on each cen tick and exit when the counter is 0: ADDR_WAIT goes to DATA_WR, DATA_WAIT goes to IDLE; a wait of 0 exits on the first cen tick.
REQ-019 Outside ADDR_WR and DATA_WR, ym_cs_n=ym_wr_n=1; ym_addr and ym_din SHALL hold their last values.
REQ-020 All ym_* outputs SHALL be registered, with no combinational path from cmd_* inputs.
REQ-021 Commands SHALL issue in FIFO order; pointers wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished with an extra pointer bit.
REQ-022 cen held 0 SHALL freeze the sequencer and counters, while FIFO pushes continue.

Reset
REQ-023 rst_n=0 SHALL asynchronously set: state=RST_HOLD, FIFO empty, ym_rst=1, ym_cs_n=1, ym_wr_n=1, ym_addr=0, ym_din=0x00, busy=1, fifo_ovf=0, cmd_ready=0.
REQ-024 cmd_ready SHALL rise on the first clk edge after rst_n deasserts; commands pushed during RST_HOLD queue until IDLE.
REQ-025 Reset mid-access SHALL abandon the command in flight and deassert strobes immediately.

Structure
REQ-026 A shared package ym2203_pkg SHALL hold the state enum, SSG_LAST_REG=0x0F, and the default wait constants.
REQ-027 The FIFO SHALL be a sub-module, jt_cmd_fifo (parameterised width/depth, registered full/empty); the FSM stays in ym2203_wr_seq.

Verification
REQ-028 Reset with cen=1 every cycle -> ym_rst high for exactly 8 cen ticks, then low; busy falls to 0.
REQ-029 Push (0x28,0xF0) with cen=1 -> 1 cycle addr strobe with din=0x28, 17 idle, 1 cycle data strobe with din=0xF0, 83 idle, then busy=0.
REQ-030 Push (0x07,0x38) -> data strobe follows the address strobe after 17 idle ticks; returns to IDLE on the next cen tick (wait 0).
REQ-031 Push 6 commands back-to-back with depth 4 -> cmd_ready low after 4, fifo_ovf=1, and the first 4 issue in order.
REQ-032 cen=1 every 4th clk -> strobes last 4 clk cycles; wait periods scale by 4.
REQ-033 Assert rst_n during DATA_WAIT with 2 queued commands -> strobes high and ym_rst=1 in the same cycle; FIFO empty and no command issues after release.

Source files
------------

// File: rtl/ym2203_pkg.sv
// YM2203 write sequencer shared types and constants.
// Holds the FSM state enum, command bundle and default bus wait counts.
package ym2203_pkg;

   typedef enum logic [2:0] {
      RST_HOLD,
      IDLE,
      ADDR_WR,
      ADDR_WAIT,
      DATA_WR,
      DATA_WAIT
   } state_e;

   typedef struct packed {
      logic [7:0] rg;
      logic [7:0] data;
   } cmd_t;

   localparam logic [7:0] SSG_LAST_REG = 8'h0F;

   localparam int FIFO_DEPTH_DEF    = 4;
   localparam int ADDR_WAIT_DEF     = 17;
   localparam int DATA_WAIT_FM_DEF  = 83;
   localparam int DATA_WAIT_SSG_DEF = 0;
   localparam int CHIP_RST_CYC_DEF  = 8;

   localparam int CNT_W = 16;

   function automatic logic is_ssg(input logic [7:0] r);
      return r <= SSG_LAST_REG;
   endfunction

endpackage

// File: rtl/jt_cmd_fifo.sv
// Small command FIFO with registered full/empty flags.
// Ports: clk, rst_n, push_i/din_i write side, pop_i/dout_o read side, full_o, empty_o.
module jt_cmd_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic         full_q, full_d;
   logic         empty_q, empty_d;
   logic         do_push, do_pop;

   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   // Extra MSB tells a full ring from an empty one.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
      empty_d = (wr_d == rd_d);
      full_d  = (wr_d[AW] != rd_d[AW]) &&
                (wr_d[AW-1:0] == rd_d[AW-1:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

   assign dout_o  = mem_q[rd_q[AW-1:0]];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/ym2203_wr_seq.sv
// Queues register writes and plays them onto the YM2203 bus with chip wait times.
// Ports: clk/rst_n, cen chip enable, cmd_* push side, ym_* chip bus, busy, fifo_ovf.
module ym2203_wr_seq
   import ym2203_pkg::*;
#(
   parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
   parameter int ADDR_WAIT     = ADDR_WAIT_DEF,
   parameter int DATA_WAIT_FM  = DATA_WAIT_FM_DEF,
   parameter int DATA_WAIT_SSG = DATA_WAIT_SSG_DEF,
   parameter int CHIP_RST_CYC  = CHIP_RST_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_reg,
   input  logic [7:0] cmd_data,
   output logic       ym_rst,
   output logic       ym_cs_n,
   output logic       ym_wr_n,
   output logic       ym_addr,
   output logic [7:0] ym_din,
   output logic       busy,
   output logic       fifo_ovf
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       data_q;
   logic             ssg_q;
   logic             alive_q;
   logic             ovf_q;
   logic             rst_q, cs_n_q, wr_n_q, addr_q;
   logic [7:0]       din_q;

   cmd_t             head;
   logic             full, empty, push, pop, last;

   // Ready stays low until the first edge out of reset.
   assign cmd_ready = alive_q && !full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = cen && (state_q == IDLE) && !empty;

   // Every hold/wait lasts max(count,1) cen periods.
   assign last = (cnt_q <= CNT_W'(1));

   jt_cmd_fifo #(
      .W     ($bits(cmd_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   ({cmd_reg, cmd_data}),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_HOLD;
         cnt_q   <= CNT_W'(CHIP_RST_CYC);
         data_q  <= 8'h00;
         ssg_q   <= 1'b0;
         alive_q <= 1'b0;
         ovf_q   <= 1'b0;
         rst_q   <= 1'b1;
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         addr_q  <= 1'b0;
         din_q   <= 8'h00;
      end else begin
         alive_q <= 1'b1;
         if (cmd_valid && !cmd_ready) ovf_q <= 1'b1;
         if (cen) begin
            unique case (state_q)
               RST_HOLD: begin
                  if (last) begin
                     state_q <= IDLE;
                     rst_q   <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               IDLE: begin
                  if (!empty) begin
                     state_q <= ADDR_WR;
                     cs_n_q  <= 1'b0;
                     wr_n_q  <= 1'b0;
                     addr_q  <= 1'b0;
                     din_q   <= head.rg;
                     data_q  <= head.data;
                     ssg_q   <= is_ssg(head.rg);
                  end
               end
               ADDR_WR: begin
                  state_q <= ym2203_pkg::ADDR_WAIT;
                  cs_n_q  <= 1'b1;
                  wr_n_q  <= 1'b1;
                  cnt_q   <= CNT_W'(ADDR_WAIT);
               end
               ym2203_pkg::ADDR_WAIT: begin
                  if (last) begin
                     state_q <= DATA_WR;
                     cs_n_q  <= 1'b0;
                     wr_n_q  <= 1'b0;
                     addr_q  <= 1'b1;
                     din_q   <= data_q;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               DATA_WR: begin
                  state_q <= DATA_WAIT;
                  cs_n_q  <= 1'b1;
                  wr_n_q  <= 1'b1;
                  cnt_q   <= ssg_q ? CNT_W'(DATA_WAIT_SSG)
                                   : CNT_W'(DATA_WAIT_FM);
               end
               DATA_WAIT: begin
                  if (last) state_q <= IDLE;
                  else      cnt_q   <= cnt_q - CNT_W'(1);
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign ym_rst   = rst_q;
   assign ym_cs_n  = cs_n_q;
   assign ym_wr_n  = wr_n_q;
   assign ym_addr  = addr_q;
   assign ym_din   = din_q;
   assign busy     = !empty || (state_q != IDLE);
   assign fifo_ovf = ovf_q;

endmodule

// File: tb/tb_ym2203_wr_seq.sv
// Randomized bench for ym2203_wr_seq against a tick-timeline model.
// Drives pushes and cen patterns; checks strobe order, timing, flags and reset.
module tb_ym2203_wr_seq;

   localparam int DEPTH = 4;
   localparam int AW    = 17;
   localparam int DWF   = 83;
   localparam int DWS   = 0;
   localparam int RSTC  = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cen = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_reg = 8'h00;
   logic [7:0] cmd_data = 8'h00;
   logic       ym_rst, ym_cs_n, ym_wr_n, ym_addr;
   logic [7:0] ym_din;
   logic       busy, fifo_ovf;

   int n_chk = 0;
   int n_pass = 0;
   int mode = 0;
   int tick = 0;
   int free_m = RSTC;
   int cyc = 0;
   int nstrobe = 0;
   int ovf_exp = 0;
   int ccnt = 0;

   typedef struct {
      int a;
      int v;
      int t;
   } ev_t;
   ev_t exp_q[$];

   ym2203_wr_seq #(
      .FIFO_DEPTH    (DEPTH),
      .ADDR_WAIT     (AW),
      .DATA_WAIT_FM  (DWF),
      .DATA_WAIT_SSG (DWS),
      .CHIP_RST_CYC  (RSTC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cen       (cen),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_reg   (cmd_reg),
      .cmd_data  (cmd_data),
      .ym_rst    (ym_rst),
      .ym_cs_n   (ym_cs_n),
      .ym_wr_n   (ym_wr_n),
      .ym_addr   (ym_addr),
      .ym_din    (ym_din),
      .busy      (busy),
      .fifo_ovf  (fifo_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int atleast1(input int x);
      return (x < 1) ? 1 : x;
   endfunction

   // mode 0: cen always, 1: every 4th clk, 2: random, 3: frozen
   always @(negedge clk) begin
      case (mode)
         0: cen = 1'b1;
         1: cen = (ccnt % 4 == 0);
         2: cen = ($urandom_range(0, 2) == 0);
         default: cen = 1'b0;
      endcase
      ccnt++;
   end

   // Timeline model: each write occupies fixed cen-tick slots.
   always @(posedge clk) begin : mon
      logic       c, hs;
      logic [7:0] r, d;
      logic       prev_cs, prev_rst;
      int         p, dw, st_tick, st_clk, st_mode, last_v, last_a;
      ev_t        e;
      c  = cen;
      hs = cmd_valid && cmd_ready;
      r  = cmd_reg;
      d  = cmd_data;
      #1;
      cyc++;
      if (!rst_n) begin
         tick   = 0;
         free_m = RSTC;
         exp_q.delete();
         prev_cs  = 1'b1;
         prev_rst = 1'b1;
      end else begin
         if (c) tick++;
         if (hs) begin
            p  = (free_m + 1 > tick + 1) ? free_m + 1 : tick + 1;
            dw = (r <= 8'h0F) ? atleast1(DWS) : atleast1(DWF);
            exp_q.push_back('{0, int'(r), p});
            exp_q.push_back('{1, int'(d), p + 1 + atleast1(AW)});
            free_m = p + 2 + atleast1(AW) + dw;
         end
         if (prev_rst && !ym_rst) chk("rst_len", tick, atleast1(RSTC));
         if (prev_cs && !ym_cs_n) begin
            nstrobe++;
            st_tick = tick;
            st_clk  = cyc;
            st_mode = mode;
            last_v  = ym_din;
            last_a  = ym_addr;
            chk("wr_n", ym_wr_n, 0);
            if (exp_q.size() == 0) chk("unexp", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("addr", ym_addr, e.a);
               chk("din", ym_din, e.v);
               chk("start", tick, e.t);
            end
         end
         if (!prev_cs && ym_cs_n) begin
            chk("len", tick - st_tick, 1);
            chk("wr_n_up", ym_wr_n, 1);
            chk("hold_din", ym_din, last_v);
            chk("hold_a", ym_addr, last_a);
            if (st_mode == 1 && mode == 1)
               chk("clk4", cyc - st_clk, 4);
         end
         prev_cs  = ym_cs_n;
         prev_rst = ym_rst;
      end
   end

   task automatic push_cmd(input logic [7:0] r, input logic [7:0] d);
      int n = 0;
      while (!cmd_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("push_to", n < 5000, 1);
      cmd_valid = 1'b1;
      cmd_reg   = r;
      cmd_data  = d;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      if (tick < free_m) chk({tag, "_busy1"}, busy, 1);
      while ((tick < free_m || exp_q.size() != 0) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_to"}, n < 20000, 1);
      chk({tag, "_busy0"}, busy, 0);
      chk({tag, "_ovf"}, fifo_ovf, ovf_exp);
   endtask

   task automatic wait_strobe(input string tag, input int a);
      int n = 0;
      while (!(ym_cs_n == 1'b0 && ym_addr == a[0]) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, n < 2000, 1);
   endtask

   initial begin
      int ns;
      int n;
      logic [7:0] r;
      repeat (3) @(negedge clk);
      chk("r_ym_rst", ym_rst, 1);
      chk("r_cs_n", ym_cs_n, 1);
      chk("r_wr_n", ym_wr_n, 1);
      chk("r_addr", ym_addr, 0);
      chk("r_din", ym_din, 0);
      chk("r_busy", busy, 1);
      chk("r_ovf", fifo_ovf, 0);
      chk("r_ready", cmd_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_up", cmd_ready, 1);
      drain("init");

      push_cmd(8'h28, 8'hF0);
      drain("fm");
      push_cmd(8'h07, 8'h38);
      drain("ssg");

      mode = 3;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1'b1;
         cmd_reg   = 8'h60 + 8'(i);
         cmd_data  = 8'hA0 + 8'(i);
         @(negedge clk);
         chk("ovf_ready", cmd_ready, int'(i < 3));
         chk("ovf_flag", fifo_ovf, int'(i >= 4));
      end
      cmd_valid = 1'b0;
      ovf_exp = 1;
      mode = 0;
      drain("ovf");

      mode = 1;
      push_cmd(8'h2A, 8'h55);
      push_cmd(8'h08, 8'h0F);
      push_cmd(8'hB4, 8'hC0);
      drain("cen4");

      mode = 2;
      for (int i = 0; i < 24; i++) begin
         r = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                         : 8'($urandom_range(16, 255));
         n = $urandom_range(0, 6);
         repeat (n) @(negedge clk);
         push_cmd(r, 8'($urandom));
      end
      drain("rnd");

      mode = 0;
      repeat (2) @(negedge clk);
      push_cmd(8'h50, 8'h44);
      wait_strobe("astb_to", 0);
      rst_n = 1'b0;
      ovf_exp = 0;
      #1;
      chk("ra_cs_n", ym_cs_n, 1);
      chk("ra_wr_n", ym_wr_n, 1);
      chk("ra_addr", ym_addr, 0);
      chk("ra_din", ym_din, 0);
      chk("ra_ym_rst", ym_rst, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drain("rst1");

      push_cmd(8'h30, 8'h11);
      wait_strobe("dstb_to", 1);
      @(negedge clk);
      chk("dwait_cs", ym_cs_n, 1);
      push_cmd(8'h40, 8'h22);
      push_cmd(8'h41, 8'h33);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rd_cs_n", ym_cs_n, 1);
      chk("rd_wr_n", ym_wr_n, 1);
      chk("rd_ym_rst", ym_rst, 1);
      chk("rd_ready", cmd_ready, 0);
      chk("rd_busy", busy, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ns = nstrobe;
      drain("rst2");
      repeat (60) @(negedge clk);
      chk("no_issue", nstrobe - ns, 0);
      chk("end_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
